mem_access: RTL

Memory-access stage of the MIPS pipeline, between the EX/MEM latch and `write_back`. Issues loads and stores to the data memory over a req/ack handshake and stalls upstream while a transaction is outstanding. Aligns and sign/zero-extends load data, replicates store data across byte lanes and flags misaligned accesses. Registers everything `write_back` consumes (the MEM/WB latch).

---
 rtl/mem_access.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// MIPS memory-access stage: req/ack data-memory port, load align/extend, store lane replication, MEM/WB latch.
// Latency 1 cycle for non-memory ops, 2+N for memory ops (N = BUSY cycles before ack); o_stall holds EX/MEM while BUSY.
module mem_access #(
  parameter int NB_REG      = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int NB_WB       = 8,
  parameter int NB_MEM_CTRL = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic [NB_REG-1:0]      i_alu_result,
  input  logic [NB_REG-1:0]      i_store_data,
  input  logic [NB_MEM_CTRL-1:0] i_mem_ctrl,
  input  logic [NB_WB-1:0]       i_wb,
  input  logic [NB_REG-1:0]      i_pc,
  output logic                   o_stall,
  output logic                   o_dmem_req,
  output logic                   o_dmem_we,
  output logic [NB_REG-1:0]      o_dmem_addr,
  output logic [3:0]             o_dmem_be,
  output logic [NB_REG-1:0]      o_dmem_wdata,
  input  logic [NB_REG-1:0]      i_dmem_rdata,
  input  logic                   i_dmem_ack,
  output logic                   o_valid,
  output logic [NB_REG-1:0]      o_reg_wb,
  output logic [NB_REG-1:0]      o_ext_mem_o,
  output logic [NB_WB-1:0]       o_wb,
  output logic [NB_REG-1:0]      o_pc,
  output logic                   o_misaligned
);

  // reg_we sits just above the 2-bit data selector, below reg_dest
  localparam int WB_WE_BIT = NB_WB - NB_REG_ADDR - 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state_q, state_d;

  logic [NB_REG-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic                we_q, we_d;
  logic [NB_REG-1:0]   sdata_q, sdata_d;
  logic [NB_WB-1:0]    wb_q, wb_d;
  logic [NB_REG-1:0]   pc_q, pc_d;

  logic                valid_q, valid_d;
  logic [NB_REG-1:0]   reg_wb_q, reg_wb_d;
  logic [NB_REG-1:0]   ext_q, ext_d;
  logic [NB_WB-1:0]    wbo_q, wbo_d;
  logic [NB_REG-1:0]   pco_q, pco_d;
  logic                misal_q, misal_d;

  logic                in_load, in_store, mem_op, misal;
  logic [1:0]          in_size;
  logic [NB_WB-1:0]    wb_no_we;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [NB_REG-1:0]   load_ext;

  assign in_load  = i_mem_ctrl[4];
  assign in_store = i_mem_ctrl[3];
  assign in_size  = i_mem_ctrl[2:1];
  assign mem_op   = i_valid & (in_load | in_store);
  assign misal    = ((in_size == 2'b01) & i_alu_result[0]) |
                    (in_size[1] & (|i_alu_result[1:0]));

  always_comb begin
    wb_no_we            = i_wb;
    wb_no_we[WB_WE_BIT] = 1'b0;
  end

  // State register plus all datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      we_q     <= 1'b0;
      sdata_q  <= '0;
      wb_q     <= '0;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      reg_wb_q <= '0;
      ext_q    <= '0;
      wbo_q    <= '0;
      pco_q    <= '0;
      misal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      we_q     <= we_d;
      sdata_q  <= sdata_d;
      wb_q     <= wb_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      reg_wb_q <= reg_wb_d;
      ext_q    <= ext_d;
      wbo_q    <= wbo_d;
      pco_q    <= pco_d;
      misal_q  <= misal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_op && !misal) state_d = BUSY;
      BUSY:    if (i_dmem_ack)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    size_d   = size_q;
    uns_d    = uns_q;
    we_d     = we_q;
    sdata_d  = sdata_q;
    wb_d     = wb_q;
    pc_d     = pc_q;
    valid_d  = 1'b0;
    reg_wb_d = reg_wb_q;
    ext_d    = ext_q;
    wbo_d    = wbo_q;
    pco_d    = pco_q;
    misal_d  = 1'b0;
    if (state_q == IDLE) begin
      if (i_valid && !mem_op) begin
        valid_d  = 1'b1;
        reg_wb_d = i_alu_result;
        wbo_d    = i_wb;
        pco_d    = i_pc;
      end else if (mem_op && misal) begin
        // Faulting access retires without touching memory or the register file
        valid_d  = 1'b1;
        reg_wb_d = i_alu_result;
        wbo_d    = wb_no_we;
        pco_d    = i_pc;
        misal_d  = 1'b1;
      end else if (mem_op) begin
        addr_d  = i_alu_result;
        size_d  = in_size;
        uns_d   = i_mem_ctrl[0];
        we_d    = in_store & ~in_load;
        sdata_d = i_store_data;
        wb_d    = i_wb;
        pc_d    = i_pc;
      end
    end else if (i_dmem_ack) begin
      valid_d  = 1'b1;
      reg_wb_d = addr_q;
      ext_d    = we_q ? '0 : load_ext;
      wbo_d    = wb_q;
      pco_d    = pc_q;
    end
  end

  always_comb begin
    byte_sel = i_dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = uns_q ? {{(NB_REG-8){1'b0}}, byte_sel}
                                : {{(NB_REG-8){byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = uns_q ? {{(NB_REG-16){1'b0}}, half_sel}
                                : {{(NB_REG-16){half_sel[15]}}, half_sel};
      default: load_ext = i_dmem_rdata;
    endcase
  end

  // Memory port is driven purely from the captured op so it stays stable until ack
  always_comb begin
    o_stall      = 1'b0;
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_dmem_addr  = '0;
    o_dmem_be    = 4'b0000;
    o_dmem_wdata = '0;
    if (state_q == BUSY) begin
      o_stall     = 1'b1;
      o_dmem_req  = 1'b1;
      o_dmem_we   = we_q;
      o_dmem_addr = {addr_q[NB_REG-1:2], 2'b00};
      case (size_q)
        2'b00: begin
          o_dmem_be    = 4'b0001 << addr_q[1:0];
          o_dmem_wdata = {4{sdata_q[7:0]}};
        end
        2'b01: begin
          o_dmem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
          o_dmem_wdata = {2{sdata_q[15:0]}};
        end
        default: begin
          o_dmem_be    = 4'b1111;
          o_dmem_wdata = sdata_q;
        end
      endcase
    end
  end

  assign o_valid      = valid_q;
  assign o_reg_wb     = reg_wb_q;
  assign o_ext_mem_o  = ext_q;
  assign o_wb         = wbo_q;
  assign o_pc         = pco_q;
  assign o_misaligned = misal_q;

endmodule
